// File: rtl/ncl_pkg.sv
// Shared NCL definitions: phase encoding of the wavefront FSM and rail indices.
// No logic here; no latency and no flow control of its own.
package ncl_pkg;

    typedef enum logic {
        NULL_PH = 1'b0,
        DATA_PH = 1'b1
    } ncl_phase_e;

    localparam int RAIL0 = 0;
    localparam int RAIL1 = 1;

endpackage

// File: rtl/ncl_dr_encode.sv
// Combinational dual-rail encoder: valid=1 drives one rail per bit, valid=0 drives NULL.
// Zero latency; no flow control.
module ncl_dr_encode #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] value,
    input  logic             valid,
    output logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] f
);

    assign t = valid ? value  : '0;
    assign f = valid ? ~value : '0;

endmodule

// File: rtl/ncl_sync_dr_counter.sv
// Clocked dual-rail counter emitting DATA/NULL wavefronts, one cycle after each deciding edge.
// Backpressure via ack_in: DATA holds until ack_in=1, NULL holds until ack_in=0.
module ncl_sync_dr_counter
    import ncl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             init,
    input  logic             ack_in,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] sum_t,
    output logic [WIDTH-1:0] sum_f,
    output logic             tc_t,
    output logic             tc_f,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    ncl_phase_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;

    logic [WIDTH-1:0] sum_t_q, sum_f_q;
    logic [WIDTH-1:0] sum_t_d, sum_f_d;
    logic [1:0]       tc_rail_q, tc_rail_d;
    logic             busy_q;

    logic             all_ones, all_zero;
    logic             data_nxt;
    logic             tc_nxt;
    logic [WIDTH-1:0] cnt_step;

    assign all_ones = &cnt_q;
    assign all_zero = ~|cnt_q;

    // Saturating/wrapping step, only consumed on the DATA->NULL edge.
    always_comb begin
        cnt_step = cnt_q;
        if (up_dn) begin
            if (all_ones) begin
                cnt_step = sat ? cnt_q : '0;
            end else begin
                cnt_step = cnt_q + ONE;
            end
        end else begin
            if (all_zero) begin
                cnt_step = sat ? cnt_q : '1;
            end else begin
                cnt_step = cnt_q - ONE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            NULL_PH: begin
                if (!ack_in) begin
                    state_d = DATA_PH;
                end
            end
            DATA_PH: begin
                if (ack_in) begin
                    state_d = NULL_PH;
                    dir_d   = up_dn;
                    if (load) begin
                        cnt_d = load_val;
                    end else if (en) begin
                        cnt_d = cnt_step;
                    end
                end
            end
            default: begin
                state_d = NULL_PH;
            end
        endcase
    end

    // Rails are encoded from next-state values and then registered, so every
    // digit of a wavefront flips on the same edge with no decode glitches.
    assign data_nxt = (state_d == DATA_PH);
    assign tc_nxt   = dir_d ? (&cnt_d) : (~|cnt_d);

    ncl_dr_encode #(
        .WIDTH (WIDTH)
    ) u_sum_enc (
        .value (cnt_d),
        .valid (data_nxt),
        .t     (sum_t_d),
        .f     (sum_f_d)
    );

    ncl_dr_encode #(
        .WIDTH (1)
    ) u_tc_enc (
        .value (tc_nxt),
        .valid (data_nxt),
        .t     (tc_rail_d[RAIL1]),
        .f     (tc_rail_d[RAIL0])
    );

    always_ff @(posedge clk) begin
        if (init) begin
            state_q   <= NULL_PH;
            cnt_q     <= '0;
            dir_q     <= 1'b1;
            sum_t_q   <= '0;
            sum_f_q   <= '0;
            tc_rail_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            sum_t_q   <= sum_t_d;
            sum_f_q   <= sum_f_d;
            tc_rail_q <= tc_rail_d;
            busy_q    <= data_nxt;
        end
    end

    assign sum_t = sum_t_q;
    assign sum_f = sum_f_q;
    assign tc_t  = tc_rail_q[RAIL1];
    assign tc_f  = tc_rail_q[RAIL0];
    assign busy  = busy_q;

endmodule

// File: tb/tb_ncl_sync_dr_counter.sv
// Directed-vector and reference-model bench for ncl_sync_dr_counter at WIDTH=4.
module tb_ncl_sync_dr_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         init, ack_in, en, up_dn, sat, load;
    logic [W-1:0] load_val;
    logic [W-1:0] sum_t, sum_f;
    logic         tc_t, tc_f, busy;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    ncl_sync_dr_counter #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .init     (init),
        .ack_in   (ack_in),
        .en       (en),
        .up_dn    (up_dn),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .sum_t    (sum_t),
        .sum_f    (sum_f),
        .tc_t     (tc_t),
        .tc_f     (tc_f),
        .busy     (busy)
    );

    // Observed word: {busy, tc_t, tc_f, sum_t, sum_f}
    function automatic logic [10:0] obs();
        return {busy, tc_t, tc_f, sum_t, sum_f};
    endfunction

    function automatic logic [10:0] dexp(input logic [3:0] c, input logic tc);
        return {1'b1, tc, ~tc, c, ~c};
    endfunction

    function automatic logic [3:0] ref_next(input logic [3:0] c, input logic ld,
                                            input logic [3:0] lv, input logic e,
                                            input logic up, input logic s);
        if (ld) return lv;
        if (!e) return c;
        if (up) return (c == 4'hF) ? (s ? 4'hF : 4'h0) : c + 4'd1;
        return (c == 4'h0) ? (s ? 4'h0 : 4'hF) : c - 4'd1;
    endfunction

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%03h expected=%03h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From NULL: present current value, load v with direction up, then present v.
    task automatic goto_value(input logic [3:0] v, input logic up);
        ack_in = 1'b0; tick();
        ack_in = 1'b1; load = 1'b1; load_val = v; up_dn = up; tick();
        load = 1'b0; ack_in = 1'b0; tick();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (((sum_t & sum_f) != '0) ||
                (busy && (((sum_t | sum_f) != 4'hF) || (tc_t == tc_f))) ||
                (!busy && ((sum_t | sum_f) != '0 || tc_t || tc_f))) begin
                failures++;
                $display("FAIL invariant actual=%03h busy=%0b at %0t", obs(), busy, $time);
            end
        end
    end

    typedef struct {
        logic        init, ack, en, up, sat, load;
        logic [3:0]  lv;
        logic [10:0] exp;
        string       name;
    } vec_t;

    function automatic vec_t mk(input logic i, input logic a, input logic e, input logic u,
                                input logic s, input logic l, input logic [3:0] lv,
                                input logic [10:0] x, input string n);
        vec_t v;
        v.init = i; v.ack = a; v.en = e; v.up = u; v.sat = s; v.load = l;
        v.lv = lv; v.exp = x; v.name = n;
        return v;
    endfunction

    vec_t tbl[24];

    logic       m_state, m_dir;
    logic [3:0] m_cnt;
    logic [10:0] m_exp;

    initial begin
        //            init ack en up sat ld lv    expected          name
        tbl[0]  = mk(1, 1, 0, 1, 1, 0, 4'h0, 11'h0,          "rst_null");
        tbl[1]  = mk(0, 0, 0, 1, 1, 0, 4'h0, dexp(4'h0, 0),  "s1_first0");
        tbl[2]  = mk(0, 1, 0, 0, 1, 1, 4'h2, 11'h0,          "s1_ld_null");
        tbl[3]  = mk(0, 0, 0, 0, 1, 0, 4'h0, dexp(4'h2, 0),  "s1_d2");
        tbl[4]  = mk(0, 1, 1, 0, 1, 0, 4'h0, 11'h0,          "s1_n");
        tbl[5]  = mk(0, 0, 1, 0, 1, 0, 4'h0, dexp(4'h1, 0),  "s1_d1");
        tbl[6]  = mk(0, 1, 1, 0, 1, 0, 4'h0, 11'h0,          "s1_n");
        tbl[7]  = mk(0, 0, 1, 0, 1, 0, 4'h0, dexp(4'h0, 1),  "s1_d0");
        tbl[8]  = mk(0, 1, 1, 0, 1, 0, 4'h0, 11'h0,          "s1_n");
        tbl[9]  = mk(0, 0, 1, 0, 1, 0, 4'h0, dexp(4'h0, 1),  "s1_d0_sat");
        tbl[10] = mk(0, 1, 1, 0, 1, 0, 4'h0, 11'h0,          "s1_n");
        tbl[11] = mk(0, 0, 1, 0, 1, 0, 4'h0, dexp(4'h0, 1),  "s1_d0_sat2");
        tbl[12] = mk(1, 0, 1, 0, 0, 0, 4'h0, 11'h0,          "rst_in_data");
        tbl[13] = mk(0, 0, 0, 1, 0, 0, 4'h0, dexp(4'h0, 0),  "s0_first0");
        tbl[14] = mk(0, 1, 0, 0, 0, 1, 4'h2, 11'h0,          "s0_ld_null");
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 4'h0, dexp(4'h2, 0),  "s0_d2");
        tbl[16] = mk(0, 1, 1, 0, 0, 0, 4'h0, 11'h0,          "s0_n");
        tbl[17] = mk(0, 0, 1, 0, 0, 0, 4'h0, dexp(4'h1, 0),  "s0_d1");
        tbl[18] = mk(0, 1, 1, 0, 0, 0, 4'h0, 11'h0,          "s0_n");
        tbl[19] = mk(0, 0, 1, 0, 0, 0, 4'h0, dexp(4'h0, 1),  "s0_d0");
        tbl[20] = mk(0, 1, 1, 0, 0, 0, 4'h0, 11'h0,          "s0_n");
        tbl[21] = mk(0, 0, 1, 0, 0, 0, 4'h0, dexp(4'hF, 0),  "s0_wrap15");
        tbl[22] = mk(0, 1, 1, 0, 0, 0, 4'h0, 11'h0,          "s0_n");
        tbl[23] = mk(0, 0, 1, 0, 0, 0, 4'h0, dexp(4'hE, 0),  "s0_d14");

        init = 1'b0; ack_in = 1'b1; en = 1'b0; up_dn = 1'b1;
        sat = 1'b0; load = 1'b0; load_val = '0;
        #1;

        for (int i = 0; i < 24; i++) begin
            init = tbl[i].init; ack_in = tbl[i].ack; en = tbl[i].en; up_dn = tbl[i].up;
            sat = tbl[i].sat; load = tbl[i].load; load_val = tbl[i].lv;
            tick();
            mon_en = 1'b1;
            chk(tbl[i].name, obs(), tbl[i].exp);
        end

        // Full up-count with wrap at WIDTH=4.
        init = 1'b1; ack_in = 1'b1; tick();
        chk("up_rst", obs(), 11'h0);
        init = 1'b0; en = 1'b1; up_dn = 1'b1; sat = 1'b0; load = 1'b0;
        for (int v = 0; v <= 16; v++) begin
            ack_in = 1'b0; tick();
            chk("up_data", obs(), dexp(v[3:0], v == 15));
            ack_in = 1'b1; tick();
            chk("up_null", obs(), 11'h0);
        end

        // DATA held stable while the consumer withholds completion.
        en = 1'b0;
        goto_value(4'h7, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("hold7", obs(), {1'b1, 1'b0, 1'b1, 4'b0111, 4'b1000});
        end
        ack_in = 1'b1; tick();
        chk("hold7_release", obs(), 11'h0);

        // Reset during DATA with dir=down; dir must return to up.
        goto_value(4'h9, 1'b0);
        chk("pre_rst9", obs(), dexp(4'h9, 0));
        init = 1'b1; tick();
        chk("rst_mid_data", obs(), 11'h0);
        init = 1'b0; ack_in = 1'b1; tick();
        chk("null_hold_a", obs(), 11'h0);
        tick();
        chk("null_hold_b", obs(), 11'h0);
        ack_in = 1'b0; tick();
        chk("post_rst_d0_up", obs(), dexp(4'h0, 0));
        ack_in = 1'b1; up_dn = 1'b1; tick();

        // load wins over en at the same edge.
        goto_value(4'hC, 1'b1);
        chk("pre_ld12", obs(), dexp(4'hC, 0));
        ack_in = 1'b1; load = 1'b1; en = 1'b1; up_dn = 1'b1; load_val = 4'h5; tick();
        chk("ld_pri_null", obs(), 11'h0);
        load = 1'b0; en = 1'b0; ack_in = 1'b0; tick();
        chk("ld_pri_d5", obs(), dexp(4'h5, 0));

        // Random controls against the reference model, starting from DATA 5, dir up.
        m_state = 1'b1; m_cnt = 4'h5; m_dir = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            init     = ($urandom_range(63) == 0);
            ack_in   = $urandom_range(1);
            en       = ($urandom_range(3) != 0);
            up_dn    = $urandom_range(1);
            sat      = $urandom_range(1);
            load     = ($urandom_range(7) == 0);
            load_val = 4'($urandom_range(15));
            if (init) begin
                m_state = 1'b0; m_cnt = 4'h0; m_dir = 1'b1;
            end else if (!m_state) begin
                if (!ack_in) m_state = 1'b1;
            end else if (ack_in) begin
                m_state = 1'b0;
                m_cnt   = ref_next(m_cnt, load, load_val, en, up_dn, sat);
                m_dir   = up_dn;
            end
            m_exp = m_state ? dexp(m_cnt, m_dir ? (m_cnt == 4'hF) : (m_cnt == 4'h0)) : 11'h0;
            tick();
            chk("rand", obs(), m_exp);
        end

        init = 1'b0;
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ncl_sync_dr_counter.md
# ncl_sync_dr_counter

Parametrised, clocked dual-rail counter that emits each count value as an NCL four-phase wavefront: a DATA wavefront, then a NULL wavefront, paced by a consumer completion signal. It succeeds the fixed 32-digit two-D counter ring. It adds configurable width, up/down counting, parallel load, count enable, and wrap/saturate modes. It lets clocked test fixtures and clocked islands drive NCL pipelines with a protocol-correct counting source.

## Interface
- WIDTH, 32, number of dual-rail digits in the count (≥2)
- clk  in  1  sole clock; all state changes on rising edge
- init  in  1  reset, synchronous, active-high
- ack_in  in  1  consumer completion: 1 = DATA wavefront fully received, 0 = NULL fully received
- en  in  1  advance count on the next update
- up_dn  in  1  1 = increment, 0 = decrement
- sat  in  1  1 = saturate at terminal value, 0 = wrap
- load  in  1  replace count with load_val on the next update; priority over en
- load_val  in  WIDTH  value for load
- sum_t  out  WIDTH  rail-1 of each digit
- sum_f  out  WIDTH  rail-0 of each digit
- tc_t, tc_f  out  1 each  dual-rail terminal-count flag for the presented value
- busy  out  1  1 while a DATA wavefront is presented

## Operation
- State machine with two states:
  - NULL_PH: all rails 0, busy=0.
  - DATA_PH: rails encode cnt, busy=1.
- Registers:
  - cnt (WIDTH bits)
  - dir (1 bit): the up_dn value captured at the last update
- Reset (init=1 at an edge): state=NULL_PH, cnt=0, dir=1. All outputs are 0 the following cycle, whatever ack_in is.
- NULL_PH → DATA_PH: at an edge where ack_in=0. cnt is unchanged.
- DATA_PH → NULL_PH: at an edge where ack_in=1. At the same edge, cnt and dir update from controls sampled at that edge:
  - load=1: cnt=load_val, dir=up_dn. en is ignored.
  - load=0, en=1, up_dn=1: cnt+1. At all-ones, the result is 0 if sat=0 and stays all-ones if sat=1.
  - load=0, en=1, up_dn=0: cnt−1. At 0, the result is all-ones if sat=0 and stays 0 if sat=1.
  - load=0, en=0: cnt held; dir=up_dn.
- In all other cases the state holds. Control inputs are don't-care outside the DATA_PH→NULL_PH edge.
- Encoding in DATA_PH:
  - sum_t[i]=cnt[i], sum_f[i]=~cnt[i].
  - tc_t=1 iff (dir=1 and cnt=all-ones) or (dir=0 and cnt=0); tc_f=~tc_t.
- Invariants:
  - sum_t[i]&sum_f[i] is never 1.
  - In DATA_PH every digit has exactly one rail high (complete wavefront). In NULL_PH all rails are 0.
  - Outputs are registered and change only on clock edges; no digit changes independently of the others.
- The first DATA wavefront after reset presents 0. Each later DATA wavefront presents the value updated at the previous DATA→NULL edge.

## Timing
- Output latency: one cycle from the deciding edge to the outputs. The ack_in=0 edge produces DATA the next cycle; the ack_in=1 edge produces NULL the next cycle.
- Minimum period: one DATA cycle plus one NULL cycle per count, i.e. 2 clocks per value when ack_in toggles every cycle.
- ack_in held at 1 in NULL_PH: the block stays NULL (no new DATA).
- ack_in held at 0 in DATA_PH: the DATA wavefront stays stable indefinitely.
- Reset mid-DATA or mid-NULL: outputs go NULL the next cycle and cnt=0. The next DATA appears only after an ack_in=0 edge.
- init has priority over every other input at the same edge.

## Structure
- Shared package ncl_pkg:
  - state encoding constants NULL_PH=1'b0, DATA_PH=1'b1
  - dual-rail rail-index constants RAIL0=0, RAIL1=1
- Sub-module ncl_dr_encode (parameter WIDTH): combinational; inputs value and valid; outputs t/f rail vectors, all 0 when valid=0. Used once for sum and once (WIDTH=1) for tc.
- Next-count logic (load/inc/dec/wrap/saturate) stays inline in the top module.

## Test plan
- Reset, then ack_in toggled every cycle, en=1, up_dn=1, WIDTH=4:
  - DATA wavefronts present 0,1,…,15,0.
  - tc_t=1 only on 15.
  - NULL between every pair.
  - rails never both high.
- WIDTH=4, load_val=4'h2, load=1, then up_dn=0, en=1, sat=1: presents 2,1,0,0,0, with tc_t=1 on each 0. The same run with sat=0 presents 2,1,0,15,14.
- ack_in held 0 for 10 cycles during DATA value 7: outputs stable at 7 (sum_t=0111, sum_f=1000), busy=1 throughout.
- init asserted during DATA value 9: next cycle all rails 0. The first DATA after release presents 0 with dir=up.
- load=1 and en=1 at the same edge with load_val=5, cnt=12: next DATA presents 5, not 13.
- Random ack_in with checker on every cycle:
  - no dual-rail conflicts
  - DATA always complete and NULL always all-zero
  - presented sequence matches the reference next-count model
